// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit unsigned adder.
// One sum/carry cell is reused once per clock, LSB first, and the carry is
// held in a flip-flop between bits. Operands are taken on a start handshake
// and the result is announced with a one-cycle done pulse.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow
// output ovf. Without the macro the port and its logic are absent.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      ADD
   } state_t;

   state_t state;
   state_t state_next;

   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             c;

   logic             s_bit;
   logic             c_next;
   logic             accept;
   logic             last;

   // Single-bit full-adder cell on the current LSBs plus the registered carry,
   // and the handshake/terminal-count decodes used by both processes.
   always_comb begin
      s_bit  = sa[0] ^ sb[0] ^ c;
      c_next = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
      accept = (state == IDLE) && start;
      last   = (state == ADD) && (cnt == LAST);
   end

   // State register; reset aborts any addition in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: start is only looked at in IDLE, so requests made
   // while an addition runs are dropped rather than queued.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = ADD;
         ADD:  if (last)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: capture operands on accept, then shift one bit per clock.
   // The visible result registers only change on the final bit, so they keep
   // the previous answer while a new addition is being worked out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa        <= '0;
         sb        <= '0;
         acc       <= '0;
         cnt       <= '0;
         c         <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (accept) begin
            sa   <= a;
            sb   <= b;
            c    <= 1'b0;
            cnt  <= '0;
            busy <= 1'b1;
         end else if (state == ADD) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            c   <= c_next;
            acc <= {s_bit, acc[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
            if (last) begin
               sum       <= {s_bit, acc[WIDTH-1:1]};
               carry_out <= c_next;
               done      <= 1'b1;
               busy      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
               // On the last bit sa[0]/sb[0] hold the operand sign bits.
               ovf       <= (sa[0] == sb[0]) && (s_bit != sa[0]);
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed, table-driven bench for serial_adder (WIDTH=8).
// Define SERIAL_ADDER_OVF_EN for both files to also check ovf.
module tb_serial_adder;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;
`endif

   int testsRun  = 0;
   int testsFail = 0;

   typedef struct {
      logic [7:0] va;
      logic [7:0] vb;
      logic [7:0] expSum;
      logic       expCarry;
      logic       expOvf;
   } vec_t;

   vec_t vecs[7];

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .carry_out (carry_out)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Waits on negedges until done is seen or the bound runs out; start is
   // dropped after the first edge unless holdStart is set.
   task automatic waitDone(input bit holdStart, output int lat, output int busyCycles);
      lat = 0;
      busyCycles = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!holdStart) start = 1'b0;
         if (busy) busyCycles++;
      end while (!done && lat < 40);
   endtask

   // One complete addition launched from a negedge with a one-cycle start.
   task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb,
                                output int lat, output int busyCycles);
      @(negedge clk);
      a = va;
      b = vb;
      start = 1'b1;
      waitDone(1'b0, lat, busyCycles);
   endtask

   initial begin
      int lat;
      int busyCycles;
      int extraDone;

      vecs[0] = '{8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
      vecs[3] = '{8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
      vecs[4] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};
      vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      vecs[6] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};

      rst = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;

      // Asynchronous reset asserted between edges.
      #3 rst = 1'b1;
      #1;
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset sum", 32'(sum), 32'h00);
      checkOutput("reset carry", 32'(carry_out), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      checkOutput("reset ovf", 32'(ovf), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // Table of single additions.
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].va, vecs[i].vb, lat, busyCycles);
         checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(WIDTH + 1));
         checkOutput($sformatf("vec%0d busy cycles", i), 32'(busyCycles), 32'(WIDTH));
         checkOutput($sformatf("vec%0d sum", i), 32'(sum), 32'(vecs[i].expSum));
         checkOutput($sformatf("vec%0d carry", i), 32'(carry_out), 32'(vecs[i].expCarry));
`ifdef SERIAL_ADDER_OVF_EN
         checkOutput($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].expOvf));
`endif
         @(negedge clk);
         checkOutput($sformatf("vec%0d done width", i), 32'(done), 32'd0);
      end

      // start pulsed mid-operation with other operands is ignored.
      @(negedge clk);
      a = 8'h33;
      b = 8'h44;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      a = 8'h12;
      b = 8'h34;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = 8'hC3;
      b = 8'h5A;
      waitDone(1'b0, lat, busyCycles);
      checkOutput("ignore latency", 32'(lat + 4), 32'(WIDTH + 1));
      checkOutput("ignore sum", 32'(sum), 32'h77);
      checkOutput("ignore carry", 32'(carry_out), 32'd0);
      extraDone = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) extraDone++;
      end
      checkOutput("ignore no second op", 32'(extraDone), 32'd0);

      // start held high: three back-to-back additions, WIDTH+1 cycles apart.
      @(negedge clk);
      a = 8'h01;
      b = 8'h02;
      start = 1'b1;
      waitDone(1'b1, lat, busyCycles);
      checkOutput("b2b0 interval", 32'(lat), 32'(WIDTH + 1));
      checkOutput("b2b0 sum", 32'(sum), 32'h03);
      checkOutput("b2b0 carry", 32'(carry_out), 32'd0);
      checkOutput("b2b0 busy in done cycle", 32'(busy), 32'd0);
      a = 8'h10;
      b = 8'h20;
      waitDone(1'b1, lat, busyCycles);
      checkOutput("b2b1 interval", 32'(lat), 32'(WIDTH + 1));
      checkOutput("b2b1 sum", 32'(sum), 32'h30);
      checkOutput("b2b1 carry", 32'(carry_out), 32'd0);
      a = 8'hF0;
      b = 8'h20;
      waitDone(1'b1, lat, busyCycles);
      start = 1'b0;
      checkOutput("b2b2 interval", 32'(lat), 32'(WIDTH + 1));
      checkOutput("b2b2 sum", 32'(sum), 32'h10);
      checkOutput("b2b2 carry", 32'(carry_out), 32'd1);
      @(negedge clk);
      checkOutput("b2b stop busy", 32'(busy), 32'd0);

      // Reset in the middle of an addition aborts it.
      @(negedge clk);
      a = 8'hAA;
      b = 8'h55;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort done", 32'(done), 32'd0);
      checkOutput("abort sum", 32'(sum), 32'h00);
      checkOutput("abort carry", 32'(carry_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      extraDone = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) extraDone++;
      end
      checkOutput("abort no done", 32'(extraDone), 32'd0);
      checkOutput("abort idle sum", 32'(sum), 32'h00);
      applyStimulus(8'hAA, 8'h55, lat, busyCycles);
      checkOutput("after abort latency", 32'(lat), 32'(WIDTH + 1));
      checkOutput("after abort sum", 32'(sum), 32'hFF);
      checkOutput("after abort carry", 32'(carry_out), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
      $finish;
   end

endmodule
